// File: rtl/call_stack_pkg.sv
// Shared stack encodings for the decoder and the return-address stack.
// Optional sticky error reporting is enabled by defining CALL_STACK_ERR_EN.
package call_stack_pkg;

    localparam logic [1:0] STACK_NOP  = 2'b00;
    localparam logic [1:0] STACK_POP  = 2'b01;
    localparam logic [1:0] STACK_PUSH = 2'b10;
    localparam logic [1:0] STACK_REPL = 2'b11;

    localparam int unsigned STACK_FULL_BIT  = 1;
    localparam int unsigned STACK_EMPTY_BIT = 0;

endpackage

// File: rtl/call_stack_if.sv
// Decoder/fetch-side bundle of the return-address stack.
interface call_stack_if #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 8
);
    import call_stack_pkg::*;

    logic [1:0]                     stack_control;
    logic [ADDR_WIDTH-1:0]          push_addr;
    logic [1:0]                     stack_flags;
    logic [ADDR_WIDTH-1:0]          ret_addr;
    logic [$clog2(DEPTH+1)-1:0]     depth_cnt;
    logic                           stack_err;

    modport master (
        output stack_control, push_addr,
        input  stack_flags, ret_addr, depth_cnt, stack_err
    );

    modport slave (
        input  stack_control, push_addr,
        output stack_flags, ret_addr, depth_cnt, stack_err
    );

endinterface

// File: rtl/call_stack_mem.sv
// DEPTH x ADDR_WIDTH register array: one synchronous write port, one asynchronous read port.
module call_stack_mem #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    localparam int unsigned IDXW      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDXW-1:0]       waddr,
    input  logic [ADDR_WIDTH-1:0] wdata,
    input  logic [IDXW-1:0]       raddr,
    output logic [ADDR_WIDTH-1:0] rdata
);

    // No reset: contents are unobservable while the pointer says empty.
    logic [ADDR_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// Return-address LIFO with saturating occupancy pointer and RST-instruction soft clear.
// Define CALL_STACK_ERR_EN to build the sticky overflow/underflow indicator.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sw_rst,
    call_stack_if.slave  bus
);

    localparam int unsigned SPW  = $clog2(DEPTH + 1);
    localparam int unsigned IDXW = $clog2(DEPTH);

    logic [SPW-1:0]        sp_q, sp_d;
    logic [IDXW-1:0]       sp_idx, top_idx, waddr;
    logic [ADDR_WIDTH-1:0] rdata;
    logic                  full, empty, clear, we;

    assign clear   = rst | sw_rst;
    assign full    = (sp_q == SPW'(DEPTH));
    assign empty   = (sp_q == '0);
    assign sp_idx  = sp_q[IDXW-1:0];
    assign top_idx = sp_idx - IDXW'(1);

    always_comb begin
        sp_d  = sp_q;
        we    = 1'b0;
        waddr = sp_idx;
        unique case (bus.stack_control)
            STACK_PUSH: begin
                if (!full) begin
                    we   = 1'b1;
                    sp_d = sp_q + SPW'(1);
                end
            end
            STACK_POP: begin
                if (!empty) begin
                    sp_d = sp_q - SPW'(1);
                end
            end
            STACK_REPL: begin
                we = 1'b1;
                if (empty) begin
                    sp_d = SPW'(1);
                end else begin
                    waddr = top_idx;
                end
            end
            default: ;
        endcase
        // A reset in the same cycle discards any pending write.
        if (clear) begin
            we   = 1'b0;
            sp_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        sp_q <= sp_d;
    end

    call_stack_mem #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (bus.push_addr),
        .raddr (top_idx),
        .rdata (rdata)
    );

    always_comb begin
        bus.stack_flags                  = 2'b00;
        bus.stack_flags[STACK_FULL_BIT]  = full;
        bus.stack_flags[STACK_EMPTY_BIT] = empty;
    end

    assign bus.ret_addr  = empty ? '0 : rdata;
    assign bus.depth_cnt = sp_q;

`ifdef CALL_STACK_ERR_EN
    logic err_q;
    logic err_event;

    assign err_event = ((bus.stack_control == STACK_PUSH) && full) ||
                       ((bus.stack_control == STACK_POP) && empty);

    always_ff @(posedge clk) begin
        if (clear) begin
            err_q <= 1'b0;
        end else if (err_event) begin
            err_q <= 1'b1;
        end
    end

    assign bus.stack_err = err_q;
`else
    assign bus.stack_err = 1'b0;
`endif

endmodule
